// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_hazard_ctrl_pkg                                             |
// | Shared constants and types for the pipeline hazard controller.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pipe_hazard_ctrl_pkg;

    localparam int c_nstage_def = 3;
    localparam int c_aw_def     = 5;
    localparam int c_cnt_w_def  = 32;
    localparam int c_fwd_rf     = 0;

    // Slot index at which a result becomes forwardable
    typedef enum logic [0:0] {
        RDY_ALU  = 1'b0,
        RDY_LOAD = 1'b1
    } rdy_class_e;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_match.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_hazard_match                                                |
// | One source register against all in-flight slots: hit/stall/sel.  |
// | PIPE_FWD_EN selects forwarding; otherwise any hit stalls.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pipe_hazard_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NSTAGE = c_nstage_def,
    parameter int AW     = c_aw_def,
    parameter int SW     = $clog2(c_nstage_def)
) (
    input  logic [AW-1:0]              src,
    input  logic                       src_used,
    input  logic [NSTAGE-1:0]          slot_vld,
    input  logic [NSTAGE-1:0][AW-1:0]  slot_rd,
    input  logic [NSTAGE-1:0][SW-1:0]  slot_rdy,
    output logic                       hit,
    output logic                       stall,
    output logic [SW:0]                sel
);

    // Walk oldest to youngest so the youngest match is the last writer
    always_comb begin
        hit   = 1'b0;
        stall = 1'b0;
        sel   = (SW+1)'(c_fwd_rf);
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (src_used && slot_vld[k] && (slot_rd[k] == src) && (src != '0)) begin
                hit = 1'b1;
`ifdef PIPE_FWD_EN
                stall = (slot_rdy[k] > SW'(k));
                sel   = stall ? (SW+1)'(c_fwd_rf) : (SW+1)'(k + 1);
`else
                stall = 1'b1;
`endif
            end
        end
    end

`ifndef PIPE_FWD_EN
    logic w_unused_rdy;
    assign w_unused_rdy = ^slot_rdy;
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                 |
// | Scoreboard of in-flight destinations; stall, flush and forward   |
// | select generation. Macro PIPE_FWD_EN enables forwarding.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter  int NSTAGE = c_nstage_def,
    parameter  int AW     = c_aw_def,
    parameter  int CNT_W  = c_cnt_w_def,
    localparam int SW     = $clog2(NSTAGE)
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_rf_we,
    input  logic [SW-1:0]    id_rdy_stage,
    input  logic             ex_redirect,
    output logic             stall_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic [SW:0]      fwd_sel_rs1_o,
    output logic [SW:0]      fwd_sel_rs2_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [NSTAGE-1:0]         r_vld;
    logic [NSTAGE-1:0][AW-1:0] r_rd;
    logic [NSTAGE-1:0][SW-1:0] r_rdy;
    logic [CNT_W-1:0]          r_stall_cnt;
    logic [CNT_W-1:0]          r_flush_cnt;

    logic w_hit_rs1, w_hit_rs2;
    logic w_stall_rs1, w_stall_rs2;
    logic w_load;
    logic w_unused_hit;

    pipe_hazard_match #(.NSTAGE(NSTAGE), .AW(AW), .SW(SW)) u_match_rs1 (
        .src      (id_rs1),
        .src_used (id_rs1_used),
        .slot_vld (r_vld),
        .slot_rd  (r_rd),
        .slot_rdy (r_rdy),
        .hit      (w_hit_rs1),
        .stall    (w_stall_rs1),
        .sel      (fwd_sel_rs1_o)
    );

    pipe_hazard_match #(.NSTAGE(NSTAGE), .AW(AW), .SW(SW)) u_match_rs2 (
        .src      (id_rs2),
        .src_used (id_rs2_used),
        .slot_vld (r_vld),
        .slot_rd  (r_rd),
        .slot_rdy (r_rdy),
        .hit      (w_hit_rs2),
        .stall    (w_stall_rs2),
        .sel      (fwd_sel_rs2_o)
    );

    assign w_unused_hit = w_hit_rs1 ^ w_hit_rs2;

    // A redirect kills the ID instruction, so it can neither stall nor enter slot 0
    assign stall_o      = id_valid & ~ex_redirect & (w_stall_rs1 | w_stall_rs2);
    assign flush_ifid_o = ex_redirect;
    assign flush_idex_o = ex_redirect;

    assign w_load = id_valid & ~stall_o & ~ex_redirect & id_rf_we & (id_rd != '0);

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_vld <= '0;
            r_rd  <= '0;
            r_rdy <= '0;
        end else begin
            for (int k = NSTAGE - 1; k > 0; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_rd[k]  <= r_rd[k-1];
                r_rdy[k] <= r_rdy[k-1];
            end
            r_vld[0] <= w_load;
            r_rd[0]  <= id_rd;
            r_rdy[0] <= id_rdy_stage;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ex_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl                                              |
// | Directed and random checks of two hazard controller instances.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_rf_we, ex_redirect;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [2:0] rdy3;

    logic        a_stall, a_fi, a_fe;
    logic [2:0]  a_sel1, a_sel2;
    logic [31:0] a_scnt, a_fcnt;
    logic        b_stall, b_fi, b_fe;
    logic [3:0]  b_sel1, b_sel2;
    logic [3:0]  b_scnt, b_fcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NSTAGE(3), .AW(5), .CNT_W(32)) dut (
        .cpu_clk(clk), .cpu_rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_rdy_stage(rdy3[1:0]), .ex_redirect(ex_redirect),
        .stall_o(a_stall), .flush_ifid_o(a_fi), .flush_idex_o(a_fe),
        .fwd_sel_rs1_o(a_sel1), .fwd_sel_rs2_o(a_sel2), .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
    );

    pipe_hazard_ctrl #(.NSTAGE(5), .AW(5), .CNT_W(4)) dut5 (
        .cpu_clk(clk), .cpu_rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_rdy_stage(rdy3), .ex_redirect(ex_redirect),
        .stall_o(b_stall), .flush_ifid_o(b_fi), .flush_idex_o(b_fe),
        .fwd_sel_rs1_o(b_sel1), .fwd_sel_rs2_o(b_sel2), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    // Reference model: list of issued writers tagged with issue cycle; age = slot index
    typedef struct {
        int     inst;
        int     rd;
        int     rdy;
        longint born;
    } ent_t;

    ent_t   q[$];
    longint cyc;
    longint m_scnt[2];
    longint m_fcnt[2];
    int     ns[2]   = '{3, 5};
    longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};

    task automatic m_reset();
        q.delete();
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            m_scnt[i] = 0;
            m_fcnt[i] = 0;
        end
    endtask

    task automatic m_src(input int i, input int s, input bit used, output bit stl, output int sel);
        longint best_age = 1000;
        int     best_rdy = 0;
        stl = 1'b0;
        sel = 0;
        if (used && s != 0) begin
            foreach (q[j]) begin
                if (q[j].inst == i && q[j].rd == s && (cyc - q[j].born) < best_age) begin
                    best_age = cyc - q[j].born;
                    best_rdy = q[j].rdy;
                end
            end
        end
        if (best_age != 1000) begin
`ifdef PIPE_FWD_EN
            if (best_rdy > best_age) stl = 1'b1;
            else sel = int'(best_age) + 1;
`else
            stl = 1'b1;
`endif
        end
    endtask

    task automatic m_out(input int i, output bit st, output int s1, output int s2);
        bit t1, t2;
        m_src(i, int'(id_rs1), id_rs1_used, t1, s1);
        m_src(i, int'(id_rs2), id_rs2_used, t2, s2);
        st = id_valid && !ex_redirect && (t1 || t2);
    endtask

    task automatic m_tick();
        bit st[2];
        int d1, d2;
        for (int i = 0; i < 2; i++) m_out(i, st[i], d1, d2);
        cyc++;
        for (int j = q.size() - 1; j >= 0; j--)
            if (cyc - q[j].born >= ns[q[j].inst]) q.delete(j);
        for (int i = 0; i < 2; i++) begin
            if (id_valid && !st[i] && !ex_redirect && id_rf_we && id_rd != 0)
                q.push_back('{i, int'(id_rd), int'(rdy3), cyc});
            if (st[i] && m_scnt[i] < cmax[i]) m_scnt[i]++;
            if (ex_redirect && m_fcnt[i] < cmax[i]) m_fcnt[i]++;
        end
    endtask

    task automatic apply(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int rd, input bit we, input int rdy, input bit rdr);
        id_valid    = v;
        id_rs1      = 5'(r1);
        id_rs1_used = u1;
        id_rs2      = 5'(r2);
        id_rs2_used = u2;
        id_rd       = 5'(rd);
        id_rf_we    = we;
        rdy3        = 3'(rdy);
        ex_redirect = rdr;
        @(negedge clk);
    endtask

    task automatic tick();
        m_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 6; c++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall actual=%0d expected=0", a_stall); end
        checks++; if (a_fi !== 1'b0 || a_fe !== 1'b0) begin errors++; $display("FAIL reset_flush actual=%0d/%0d expected=0/0", a_fi, a_fe); end
        checks++; if (a_sel1 !== 3'd0 || a_sel2 !== 3'd0) begin errors++; $display("FAIL reset_sel actual=%0d/%0d expected=0/0", a_sel1, a_sel2); end
        checks++; if (a_scnt !== 32'd0 || a_fcnt !== 32'd0) begin errors++; $display("FAIL reset_cnt actual=%0d/%0d expected=0/0", a_scnt, a_fcnt); end
        checks++; if (b_scnt !== 4'd0 || b_fcnt !== 4'd0) begin errors++; $display("FAIL reset_cnt5 actual=%0d/%0d expected=0/0", b_scnt, b_fcnt); end
    endtask

    task automatic test_fwd_alu();
        apply(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        apply(1, 5, 1, 5, 1, 6, 1, 0, 0);
`ifdef PIPE_FWD_EN
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL alu_stall actual=%0d expected=0", a_stall); end
        checks++; if (a_sel1 !== 3'd1) begin errors++; $display("FAIL alu_sel1 actual=%0d expected=1", a_sel1); end
        checks++; if (a_sel2 !== 3'd1) begin errors++; $display("FAIL alu_sel2 actual=%0d expected=1", a_sel2); end
        tick();
`else
        for (int c = 0; c < 3; c++) begin
            checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL nofwd_stall cycle=%0d actual=%0d expected=1", c, a_stall); end
            tick();
            apply(1, 5, 1, 5, 1, 6, 1, 0, 0);
        end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL nofwd_release actual=%0d expected=0", a_stall); end
        checks++; if (a_sel1 !== 3'd0) begin errors++; $display("FAIL nofwd_sel1 actual=%0d expected=0", a_sel1); end
        tick();
`endif
        drain();
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        apply(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        apply(1, 7, 1, 0, 1, 8, 1, 0, 0);
        c0 = a_scnt;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_stall actual=%0d expected=1", a_stall); end
        tick();
        checks++; if (a_scnt !== c0 + 32'd1) begin errors++; $display("FAIL lu_cnt actual=%0d expected=%0d", a_scnt, c0 + 32'd1); end
`ifdef PIPE_FWD_EN
        apply(1, 7, 1, 0, 1, 8, 1, 0, 0);
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_release actual=%0d expected=0", a_stall); end
        checks++; if (a_sel1 !== 3'd2) begin errors++; $display("FAIL lu_sel1 actual=%0d expected=2", a_sel1); end
        checks++; if (a_sel2 !== 3'd0) begin errors++; $display("FAIL lu_sel2 actual=%0d expected=0", a_sel2); end
        tick();
`endif
        drain();
    endtask

    task automatic test_x0();
        apply(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        apply(1, 0, 1, 0, 1, 9, 1, 0, 0);
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL x0_stall actual=%0d expected=0", a_stall); end
        checks++; if (a_sel1 !== 3'd0 || a_sel2 !== 3'd0) begin errors++; $display("FAIL x0_sel actual=%0d/%0d expected=0/0", a_sel1, a_sel2); end
        tick();
        drain();
    endtask

    task automatic test_redirect();
        logic [31:0] f0;
        apply(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        apply(1, 7, 1, 0, 0, 9, 1, 0, 1);
        f0 = a_fcnt;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL redir_stall actual=%0d expected=0", a_stall); end
        checks++; if (a_fi !== 1'b1 || a_fe !== 1'b1) begin errors++; $display("FAIL redir_flush actual=%0d/%0d expected=1/1", a_fi, a_fe); end
        tick();
        checks++; if (a_fcnt !== f0 + 32'd1) begin errors++; $display("FAIL redir_cnt actual=%0d expected=%0d", a_fcnt, f0 + 32'd1); end
        apply(1, 9, 1, 0, 0, 10, 1, 0, 0);
        checks++; if (a_stall !== 1'b0 || a_sel1 !== 3'd0) begin errors++; $display("FAIL redir_bubble actual=%0d/%0d expected=0/0", a_stall, a_sel1); end
        checks++; if (a_fi !== 1'b0) begin errors++; $display("FAIL redir_clear actual=%0d expected=0", a_fi); end
        tick();
        drain();
    endtask

    task automatic test_random();
        bit st0, st1;
        int e01, e02, e11, e12;
        for (int c = 0; c < 400; c++) begin
            apply(($urandom_range(9) != 0), $urandom_range(3), $urandom_range(1), $urandom_range(3),
                  $urandom_range(1), $urandom_range(3), $urandom_range(1), $urandom_range(1),
                  ($urandom_range(9) == 0));
            m_out(0, st0, e01, e02);
            m_out(1, st1, e11, e12);
            checks++; if (a_stall !== st0) begin errors++; $display("FAIL rnd_stall3 cyc=%0d actual=%0d expected=%0d", c, a_stall, st0); end
            checks++; if (b_stall !== st1) begin errors++; $display("FAIL rnd_stall5 cyc=%0d actual=%0d expected=%0d", c, b_stall, st1); end
            checks++; if (a_fi !== ex_redirect || b_fe !== ex_redirect) begin errors++; $display("FAIL rnd_flush cyc=%0d actual=%0d/%0d expected=%0d", c, a_fi, b_fe, ex_redirect); end
            if (id_valid && !ex_redirect && !st0) begin
                checks++; if (a_sel1 !== 3'(e01) || a_sel2 !== 3'(e02)) begin errors++; $display("FAIL rnd_sel3 cyc=%0d actual=%0d/%0d expected=%0d/%0d", c, a_sel1, a_sel2, e01, e02); end
            end
            if (id_valid && !ex_redirect && !st1) begin
                checks++; if (b_sel1 !== 4'(e11) || b_sel2 !== 4'(e12)) begin errors++; $display("FAIL rnd_sel5 cyc=%0d actual=%0d/%0d expected=%0d/%0d", c, b_sel1, b_sel2, e11, e12); end
            end
            tick();
            checks++; if (a_scnt !== 32'(m_scnt[0]) || a_fcnt !== 32'(m_fcnt[0])) begin errors++; $display("FAIL rnd_cnt3 cyc=%0d actual=%0d/%0d expected=%0d/%0d", c, a_scnt, a_fcnt, m_scnt[0], m_fcnt[0]); end
            checks++; if (b_scnt !== 4'(m_scnt[1]) || b_fcnt !== 4'(m_fcnt[1])) begin errors++; $display("FAIL rnd_cnt5 cyc=%0d actual=%0d/%0d expected=%0d/%0d", c, b_scnt, b_fcnt, m_scnt[1], m_fcnt[1]); end
        end
        drain();
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 20; c++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
        for (int c = 0; c < 16; c++) begin
            apply(1, 0, 0, 0, 0, 7, 1, 1, 0);
            tick();
            apply(1, 7, 1, 0, 0, 8, 1, 0, 0);
            tick();
            apply(1, 7, 1, 0, 0, 8, 1, 0, 0);
            tick();
        end
        checks++; if (b_fcnt !== 4'hF) begin errors++; $display("FAIL sat_flush5 actual=%0d expected=15", b_fcnt); end
        checks++; if (b_scnt !== 4'hF) begin errors++; $display("FAIL sat_stall5 actual=%0d expected=15", b_scnt); end
        checks++; if (a_fcnt !== 32'(m_fcnt[0]) || a_scnt !== 32'(m_scnt[0])) begin errors++; $display("FAIL sat_cnt3 actual=%0d/%0d expected=%0d/%0d", a_fcnt, a_scnt, m_fcnt[0], m_scnt[0]); end
        drain();
    endtask

    task automatic test_reset_mid();
        apply(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        apply(1, 7, 1, 0, 0, 8, 1, 0, 0);
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre actual=%0d expected=1", a_stall); end
        #1 rst = 1'b1;
        #1;
        m_reset();
        checks++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall actual=%0d/%0d expected=0/0", a_stall, b_stall); end
        checks++; if (a_scnt !== 32'd0 || a_fcnt !== 32'd0 || b_scnt !== 4'd0) begin errors++; $display("FAIL rstmid_cnt actual=%0d/%0d/%0d expected=0/0/0", a_scnt, a_fcnt, b_scnt); end
        @(posedge clk);
        #1 rst = 1'b0;
        apply(1, 7, 1, 0, 0, 8, 1, 0, 0);
        checks++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL rstmid_empty actual=%0d/%0d expected=0/0", a_stall, b_stall); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_rf_we = 0; rdy3 = 0; ex_redirect = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_fwd_alu();
        test_load_use();
        test_x0();
        test_redirect();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
